mult_product_accumulator: RTL and testbench
===========================================

# mult_product_accumulator

Downstream consumer of the 24-bit unsigned multiplier's 48-bit product. It accepts one product per cycle over a valid/ready handshake and accumulates a block of `len` products into a wide unsigned sum (dot-product style). It presents the result on a registered valid/ready output port with a sticky overflow/saturation flag. It is the block-level result stage behind the multiplier in the approximate-MAC datapath.

## Interface
- `IN_WIDTH`, 48, product width; matches multiplier `out`.
- `ACC_WIDTH`, 64, accumulator and result width; must be ≥ `IN_WIDTH`.
- `CNT_WIDTH`, 16, width of the block-length and beat counter.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `in_prod`  in  IN_WIDTH  product from the multiplier, treated as unsigned.
- `in_valid`  in  1  `in_prod` is valid.
- `in_ready`  out  1  block can accept a beat this cycle.
- `len`  in  CNT_WIDTH  block length; sampled only on the first beat of a block. `0` is treated as 1.
- `out_sum`  out  ACC_WIDTH  accumulated block sum.
- `out_valid`  out  1  `out_sum`/`out_ovf` valid.
- `out_ready`  in  1  downstream accepts the result.
- `out_ovf`  out  1  block overflowed; `out_sum` saturated to all ones.
- `busy`  out  1  high while a block is partially accumulated or a result is pending.

## Operation
- A beat is accepted when `in_valid && in_ready` at a rising edge. A result is consumed when `out_valid && out_ready`.
- **States:**
  - `IDLE`: `in_ready=1`, `out_valid=0`.
  - `ACCUM`: `in_ready=1`, `out_valid=0`.
  - `HOLD`: `out_valid=1`, `in_ready=out_ready`.
- **IDLE**, on accept:
  - Latch `L = (len==0) ? 1 : len`.
  - `acc <= zero-extended in_prod`, `cnt <= 1`, `ovf <= 0`.
  - Next state is `HOLD` if `L==1`, else `ACCUM`.
- **ACCUM**, on accept:
  - `acc <= acc + in_prod`, `cnt <= cnt+1`.
  - When `cnt+1 == L`, go to `HOLD`.
  - With no accept, hold all state; bubbles are allowed anywhere.
- **Arithmetic:** unsigned add with carry at bit `ACC_WIDTH`.
  - On carry: `acc` saturates to all ones and `ovf` is set.
  - Both stay sticky for the rest of the block; further adds leave `acc` at all ones.
- **HOLD:**
  - `out_sum=acc` and `out_ovf=ovf`, both stable until consumed.
  - On consume without a simultaneous input accept: go to `IDLE`.
  - On consume with `in_valid=1` in the same cycle: the beat is accepted as the first beat of the next block (IDLE rules apply). There is no bubble between blocks.
  - Without `out_ready`: `in_ready=0` (backpressure propagates).
- `busy = (state != IDLE)`.
- **Reset (any time, including mid-block or in `HOLD`):**
  - State → `IDLE`, and the partial block or pending result is discarded.
  - `acc=0`, `cnt=0`, `ovf=0`, `L=1`.
  - Output reset values: `out_valid=0`, `out_sum=0`, `out_ovf=0`, `busy=0`, `in_ready=1` once reset deasserts (0 while `rst` is high).
- `len` changes mid-block are ignored.

## Timing
- Throughput: one beat per cycle while `in_ready=1`.
- Latency: last beat accepted at edge k → `out_valid=1` from edge k (visible in cycle k+1). Sum is registered, with no combinational path from `in_prod` to `out_sum`.
- `in_ready` depends combinationally on `out_ready` in `HOLD` only. There is no combinational path from `in_valid` to any output.
- Minimum block period is L cycles; back-to-back blocks need no idle cycle when `out_ready=1`.
- Target clock is the multiplier's 0.6 ns period; the ACC_WIDTH adder is the critical path.

## Test plan
- **Reset state:** assert `rst` asynchronously mid-cycle → `out_valid=0`, `out_sum=0`, `out_ovf=0`, `busy=0`, `in_ready=1` after release.
- **Basic block:** `len=4`, products 3, 5, 7, 9 on consecutive cycles, `out_ready=1` → `out_valid` for one cycle after the 4th beat, `out_sum=24`, `out_ovf=0`.
- **Length 0/1 and bubbles:**
  - `len=0` with product `0xFFFFFE000001` → `out_sum=0x0000FFFFFE000001` one cycle later.
  - `len=3` with `in_valid` gaps between beats → sum is correct, and the count ignores bubbles.
- **Backpressure and back-to-back:**
  - `len=2`, hold `out_ready=0` for 5 cycles → `in_ready=0` and `out_sum` stable throughout.
  - Raise `out_ready` with `in_valid=1` → the new block's first beat is accepted in the same cycle.
- **Saturation:** `ACC_WIDTH=48`, `len=3`, three products `0xFFFFFE000001` → `out_sum=0xFFFFFFFFFFFF`, `out_ovf=1`. The next block with `len=1`, product 2 → `out_sum=2`, `out_ovf=0`.
- **Reset mid-block:** `len=4`, two beats accepted, pulse `rst` → no `out_valid`. A fresh `len=2` block with products 10, 20 → `out_sum=30`.

Source files
------------

// File: rtl/mult_product_accumulator.sv
// Result stage behind the 24-bit multiplier: accumulates blocks of `len`
// 48-bit products into a saturating wide sum, presented on a valid/ready port.
module mult_product_accumulator #(
  parameter int unsigned IN_WIDTH  = 48,
  parameter int unsigned ACC_WIDTH = 64,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IN_WIDTH-1:0]  in_prod,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [CNT_WIDTH-1:0] len,
  output logic [ACC_WIDTH-1:0] out_sum,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_ovf,
  output logic                 busy
);

  localparam int unsigned SUM_W = ACC_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t               state;
  logic [ACC_WIDTH-1:0] acc;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] lat_len;
  logic                 ovf;

  logic                 accept;
  logic                 first_beat;
  logic                 consume_only;
  logic [CNT_WIDTH-1:0] len_eff;
  logic [CNT_WIDTH-1:0] cnt_inc;
  logic [SUM_W-1:0]     sum_wide;
  logic                 carry;
  logic [ACC_WIDTH-1:0] acc_next;

  // Only HOLD can stall the producer; nothing is accepted while in reset.
  assign in_ready     = !rst && ((state != HOLD) || out_ready);
  assign accept       = in_valid && in_ready;
  assign first_beat   = accept && (state != ACCUM);
  assign consume_only = (state == HOLD) && out_ready && !in_valid;

  assign len_eff  = (len == '0) ? CNT_WIDTH'(1) : len;
  assign cnt_inc  = cnt + CNT_WIDTH'(1);
  assign sum_wide = {1'b0, acc} + SUM_W'(in_prod);
  assign carry    = sum_wide[ACC_WIDTH];
  // Once a block overflows the sum is pinned at all ones until the next block.
  assign acc_next = (ovf || carry) ? '1 : sum_wide[ACC_WIDTH-1:0];

  assign out_sum = acc;
  assign out_ovf = ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      lat_len   <= CNT_WIDTH'(1);
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else if (consume_only) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else if (first_beat) begin
      // Entered from IDLE, or from HOLD when the result is taken in the same cycle.
      lat_len <= len_eff;
      acc     <= ACC_WIDTH'(in_prod);
      cnt     <= CNT_WIDTH'(1);
      ovf     <= 1'b0;
      busy    <= 1'b1;
      if (len_eff == CNT_WIDTH'(1)) begin
        state     <= HOLD;
        out_valid <= 1'b1;
      end else begin
        state     <= ACCUM;
        out_valid <= 1'b0;
      end
    end else if (accept) begin
      acc <= acc_next;
      cnt <= cnt_inc;
      ovf <= ovf | carry;
      if (cnt_inc == lat_len) begin
        state     <= HOLD;
        out_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mult_product_accumulator.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// block-level reference model (queue of beats, wide-integer sums).
module tb_mult_product_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic [47:0] in_prod;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] len;
  logic [63:0] out_sum;
  logic        out_valid;
  logic        out_ready;
  logic        out_ovf;
  logic        busy;

  logic [47:0] s_prod;
  logic        s_valid;
  logic        s_in_ready;
  logic [15:0] s_len;
  logic [47:0] s_sum;
  logic        s_out_valid;
  logic        s_out_ready;
  logic        s_ovf;
  logic        s_busy;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [47:0]  m_beats[$];
  int           m_len;
  bit           m_open;
  bit           m_pend;
  logic [63:0]  m_sum;
  bit           m_ovf;

  always #5 clk = ~clk;

  mult_product_accumulator dut (
    .clk(clk), .rst(rst), .in_prod(in_prod), .in_valid(in_valid),
    .in_ready(in_ready), .len(len), .out_sum(out_sum), .out_valid(out_valid),
    .out_ready(out_ready), .out_ovf(out_ovf), .busy(busy)
  );

  mult_product_accumulator #(.ACC_WIDTH(48)) dut48 (
    .clk(clk), .rst(rst), .in_prod(s_prod), .in_valid(s_valid),
    .in_ready(s_in_ready), .len(s_len), .out_sum(s_sum), .out_valid(s_out_valid),
    .out_ready(s_out_ready), .out_ovf(s_ovf), .busy(s_busy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit model_ready();
    return !m_pend || (out_ready == 1'b1);
  endfunction

  task automatic model_clear();
    m_beats.delete();
    m_open = 0;
    m_pend = 0;
    m_len  = 1;
    m_sum  = '0;
    m_ovf  = 0;
  endtask

  // Close a block: exact wide sum of all beats, saturated if it exceeds 64 bits.
  task automatic model_finish();
    logic [127:0] total;
    total = '0;
    foreach (m_beats[i]) total += 128'(m_beats[i]);
    m_ovf  = (total > 128'hFFFF_FFFF_FFFF_FFFF);
    m_sum  = m_ovf ? 64'hFFFF_FFFF_FFFF_FFFF : total[63:0];
    m_pend = 1;
    m_open = 0;
    m_beats.delete();
  endtask

  // One cycle on the 64-bit instance: check outputs, drive, model the edge.
  task automatic step(input logic v, input logic [47:0] p, input logic [15:0] l, input logic r);
    bit rdy;
    bit consumed;
    @(negedge clk);
    chk("out_valid", 64'(out_valid), 64'(m_pend));
    chk("busy", 64'(busy), 64'(m_pend || m_open));
    if (m_pend) begin
      chk("out_sum", out_sum, m_sum);
      chk("out_ovf", 64'(out_ovf), 64'(m_ovf));
    end
    in_valid  = v;
    in_prod   = p;
    len       = l;
    out_ready = r;
    #1;
    rdy = model_ready();
    chk("in_ready", 64'(in_ready), 64'(rdy));
    @(posedge clk);
    consumed = m_pend && r;
    if (consumed) m_pend = 0;
    if (v && rdy) begin
      if (!m_open) begin
        m_open = 1;
        m_len  = (l == 0) ? 1 : int'(l);
        m_beats.delete();
      end
      m_beats.push_back(p);
      if (m_beats.size() == m_len) model_finish();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_sum", out_sum, 64'd0);
    chk("rst_out_ovf", 64'(out_ovf), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_in_ready_held", 64'(in_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_in_ready_rel", 64'(in_ready), 64'd1);
    model_clear();
  endtask

  task automatic s_step(input logic v, input logic [47:0] p, input logic [15:0] l, input logic r);
    @(negedge clk);
    s_valid = v; s_prod = p; s_len = l; s_out_ready = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    in_valid = 0; in_prod = '0; len = '0; out_ready = 1'b1;
    s_valid = 0; s_prod = '0; s_len = '0; s_out_ready = 1'b1;
    model_clear();
    do_reset();

    // Basic block of four
    step(1, 48'd3, 16'd4, 1);
    step(1, 48'd5, 16'd4, 1);
    step(1, 48'd7, 16'd4, 1);
    step(1, 48'd9, 16'd4, 1);
    #1 chk("basic_sum", out_sum, 64'd24);
    chk("basic_valid", 64'(out_valid), 64'd1);
    step(0, 48'd0, 16'd4, 1);
    #1 chk("basic_valid_one_cycle", 64'(out_valid), 64'd0);

    // len=0 treated as a single-beat block
    step(1, 48'hFFFF_FE00_0001, 16'd0, 1);
    #1 chk("len0_sum", out_sum, 64'h0000_FFFF_FE00_0001);
    chk("len0_ovf", 64'(out_ovf), 64'd0);
    step(0, 48'd0, 16'd0, 1);

    // len=3 with bubbles; len changes mid-block are ignored
    step(1, 48'd100, 16'd3, 1);
    step(0, 48'd999, 16'd1, 1);
    step(1, 48'd200, 16'd7, 1);
    step(0, 48'd999, 16'd1, 1);
    step(0, 48'd999, 16'd1, 1);
    step(1, 48'd300, 16'd1, 1);
    #1 chk("bubble_sum", out_sum, 64'd600);
    step(0, 48'd0, 16'd0, 1);

    // Backpressure then back-to-back takeover
    step(1, 48'd11, 16'd2, 1);
    step(1, 48'd22, 16'd2, 0);
    for (int i = 0; i < 5; i++) begin
      step(1, 48'd77, 16'd1, 0);
      #1 chk("bp_sum_stable", out_sum, 64'd33);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
    end
    step(1, 48'd77, 16'd1, 1);
    #1 chk("b2b_sum", out_sum, 64'd77);
    chk("b2b_valid", 64'(out_valid), 64'd1);
    step(0, 48'd0, 16'd0, 1);

    // Saturation on the 48-bit accumulator instance
    s_step(1, 48'hFFFF_FE00_0001, 16'd3, 1);
    s_step(1, 48'hFFFF_FE00_0001, 16'd3, 1);
    s_step(1, 48'hFFFF_FE00_0001, 16'd3, 1);
    chk("sat_sum", 64'(s_sum), 64'h0000_FFFF_FFFF_FFFF);
    chk("sat_ovf", 64'(s_ovf), 64'd1);
    chk("sat_valid", 64'(s_out_valid), 64'd1);
    s_step(1, 48'd2, 16'd1, 1);
    chk("sat_next_sum", 64'(s_sum), 64'd2);
    chk("sat_next_ovf", 64'(s_ovf), 64'd0);
    s_step(0, 48'd0, 16'd0, 1);
    chk("sat_idle_busy", 64'(s_busy), 64'd0);

    // Reset mid-block discards the partial sum
    step(1, 48'd5, 16'd4, 1);
    step(1, 48'd6, 16'd4, 1);
    do_reset();
    step(0, 48'd0, 16'd0, 1);
    step(1, 48'd10, 16'd2, 1);
    step(1, 48'd20, 16'd2, 1);
    #1 chk("post_rst_sum", out_sum, 64'd30);
    step(0, 48'd0, 16'd0, 1);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic [47:0] p;
      p = {16'($urandom), 32'($urandom)};
      step(($urandom % 4) != 0, p, 16'($urandom % 6), ($urandom % 3) != 0);
    end
    step(0, 48'd0, 16'd0, 1);
    step(0, 48'd0, 16'd0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
